// File: rtl/bist_misr_checker.sv
// Output response analyser: compacts CUT responses into a MISR signature
// and reports pass/fail against a golden signature at the end of a run.
module bist_misr_checker #(
  parameter int                  NUM_BITS     = 8,
  parameter logic [NUM_BITS-1:0] POLY         = 8'h1D,
  parameter logic [NUM_BITS-1:0] SEED         = '0,
  parameter int                  NUM_PATTERNS = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic                data_valid,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic [NUM_BITS-1:0] golden,
  output logic                busy,
  output logic [NUM_BITS-1:0] signature,
  output logic                done,
  output logic                pass,
  output logic                fail
);

  localparam int CW = $clog2(NUM_PATTERNS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] sig_q, sig_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;

  // One MISR step: shift left, fold the dropped MSB back through the taps,
  // then XOR in the new response word.
  function automatic logic [NUM_BITS-1:0] misr_step(
    input logic [NUM_BITS-1:0] cur,
    input logic [NUM_BITS-1:0] din
  );
    logic [NUM_BITS-1:0] shifted;
    shifted = {cur[NUM_BITS-2:0], 1'b0};
    if (cur[NUM_BITS-1]) begin
      shifted = shifted ^ POLY;
    end
    return shifted ^ din;
  endfunction

  // Next-state, signature, count and verdict logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            sig_d   = SEED;
            cnt_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
          end
        end
        RUN: begin
          if (data_valid) begin
            sig_d = misr_step(sig_q, data_in);
            if (cnt_q == LAST_CNT) begin
              state_d = CHECK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          pass_d  = (sig_q == golden);
          fail_d  = (sig_q != golden);
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any run in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Bench: a small 4-bit instance and a default 8-bit instance, each checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_bist_misr_checker;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Instance A: NUM_BITS=4, POLY=3, SEED=0, NUM_PATTERNS=3
  logic       a_start = 0, a_abort = 0, a_valid = 0;
  logic [3:0] a_din = '0, a_gold = '0, a_sig;
  logic       a_busy, a_done, a_pass, a_fail;

  // Instance B: default parameters
  logic       b_start = 0, b_abort = 0, b_valid = 0;
  logic [7:0] b_din = '0, b_gold = '0, b_sig;
  logic       b_busy, b_done, b_pass, b_fail;

  bist_misr_checker #(.NUM_BITS(4), .POLY(4'h3), .SEED(4'h0), .NUM_PATTERNS(3)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(a_start), .abort(a_abort),
    .data_valid(a_valid), .data_in(a_din), .golden(a_gold),
    .busy(a_busy), .signature(a_sig), .done(a_done), .pass(a_pass), .fail(a_fail));

  bist_misr_checker dut_b (
    .clk(clk), .n_rst(n_rst), .start(b_start), .abort(b_abort),
    .data_valid(b_valid), .data_in(b_din), .golden(b_gold),
    .busy(b_busy), .signature(b_sig), .done(b_done), .pass(b_pass), .fail(b_fail));

  // Model: phase 0 idle, 1 collecting, 2 checking, 3 finished
  typedef struct packed {
    int ph;
    int sig;
    int beats;
    bit pass;
    bit fail;
  } mdl_t;

  localparam mdl_t MDL_RST = '{ph: 0, sig: 0, beats: 0, pass: 1'b0, fail: 1'b0};
  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  // Multiply by x modulo P(x) over GF(2), then add the response word.
  function automatic int gf_step(int s, int d, int n, int poly);
    int t;
    t = s << 1;
    if (((t >> n) & 1) != 0) t = t ^ ((1 << n) | poly);
    return (t ^ d) & ((1 << n) - 1);
  endfunction

  function automatic mdl_t model_next(mdl_t m, bit st, bit ab, bit v, int d, int g,
                                      int n, int poly, int seed, int np);
    mdl_t r;
    r = m;
    if (ab) begin
      r.ph = 0; r.pass = 0; r.fail = 0;
      return r;
    end
    if (m.ph == 0 || m.ph == 3) begin
      if (st) begin
        r.ph = 1; r.sig = seed; r.beats = 0; r.pass = 0; r.fail = 0;
      end
    end else if (m.ph == 1) begin
      if (v) begin
        r.sig = gf_step(m.sig, d, n, poly);
        r.beats = m.beats + 1;
        if (r.beats == np) r.ph = 2;
      end
    end else begin
      r.pass = (m.sig == g);
      r.fail = (m.sig != g);
      r.ph = 3;
    end
    return r;
  endfunction

  // Advance both models with the inputs seen at each rising edge.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ma <= MDL_RST;
      mb <= MDL_RST;
    end else begin
      ma <= model_next(ma, a_start, a_abort, a_valid, int'(a_din), int'(a_gold), 4, 3, 0, 3);
      mb <= model_next(mb, b_start, b_abort, b_valid, int'(b_din), int'(b_gold), 8, 'h1D, 0, 16);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_busy", a_busy, (ma.ph == 1 || ma.ph == 2) ? 1 : 0);
      chk("a_done", a_done, (ma.ph == 3) ? 1 : 0);
      chk("a_sig",  a_sig,  ma.sig);
      chk("a_pass", a_pass, ma.pass);
      chk("a_fail", a_fail, ma.fail);
      chk("b_busy", b_busy, (mb.ph == 1 || mb.ph == 2) ? 1 : 0);
      chk("b_done", b_done, (mb.ph == 3) ? 1 : 0);
      chk("b_sig",  b_sig,  mb.sig);
      chk("b_pass", b_pass, mb.pass);
      chk("b_fail", b_fail, mb.fail);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go();
    a_start = 1; tick(); a_start = 0;
  endtask

  task automatic a_beat(input logic [3:0] d);
    a_valid = 1; a_din = d; tick(); a_valid = 0;
  endtask

  task automatic b_go();
    b_start = 1; tick(); b_start = 0;
  endtask

  task automatic b_beat(input logic [7:0] d);
    b_valid = 1; b_din = d; tick(); b_valid = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_sig", a_sig, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    n_rst = 1;
    chk_en = 1;
    tick();

    // Run 1: 1,2,4 with golden 4 -> pass
    a_gold = 4'h4;
    a_go();
    a_beat(4'h1); chk("t1_s1", a_sig, 'h1);
    a_beat(4'h2); chk("t1_s2", a_sig, 'h0);
    a_beat(4'h4); chk("t1_s3", a_sig, 'h4);
    chk("t1_check_busy", a_busy, 1);
    chk("t1_check_done", a_done, 0);
    tick();
    chk("t1_done", a_done, 1);
    chk("t1_pass", a_pass, 1);
    chk("t1_fail", a_fail, 0);

    // Run 2: F,F,F -> F,2,B -> fail
    a_go();
    a_beat(4'hF); chk("t2_s1", a_sig, 'hF);
    a_beat(4'hF); chk("t2_s2", a_sig, 'h2);
    a_beat(4'hF); chk("t2_s3", a_sig, 'hB);
    tick();
    chk("t2_fail", a_fail, 1);
    chk("t2_pass", a_pass, 0);

    // Run 3: gaps in valid, data toggling while invalid
    a_go();
    a_beat(4'hF);
    a_din = 4'h5; tick(); chk("t3_gap_busy", a_busy, 1);
    a_din = 4'hA; tick(); chk("t3_gap_sig", a_sig, 'hF);
    a_beat(4'hF);
    a_din = 4'h7; tick(); chk("t3_gap2_busy", a_busy, 1);
    a_beat(4'hF); chk("t3_final", a_sig, 'hB);
    tick();
    chk("t3_fail", a_fail, 1);

    // Abort after two beats with start in the same cycle
    a_go();
    a_beat(4'h1);
    a_beat(4'h2);
    a_abort = 1; a_start = 1; tick(); a_abort = 0; a_start = 0;
    chk("ab_busy", a_busy, 0);
    chk("ab_done", a_done, 0);
    a_go();
    a_beat(4'h1); a_beat(4'h2); a_beat(4'h4);
    tick();
    chk("ab_sig", a_sig, 'h4);
    chk("ab_pass", a_pass, 1);

    // Reset mid-run
    a_go();
    a_beat(4'hF);
    #3 n_rst = 0;
    #1;
    chk("mr_sig", a_sig, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_pass", a_pass, 0);
    chk("mr_fail", a_fail, 0);
    tick();
    n_rst = 1;
    tick();

    // start ignored in RUN and CHECK; start in DONE restarts
    a_go();
    a_beat(4'h1);
    a_go(); chk("ign_run_sig", a_sig, 'h1); chk("ign_run_busy", a_busy, 1);
    a_beat(4'h2); a_beat(4'h4);
    a_go(); chk("ign_chk_done", a_done, 1); chk("ign_chk_pass", a_pass, 1);
    a_go();
    chk("rs_busy", a_busy, 1);
    chk("rs_pass", a_pass, 0);
    chk("rs_fail", a_fail, 0);
    chk("rs_sig", a_sig, 0);
    a_beat(4'h3); a_beat(4'h9); a_beat(4'hC);
    tick(); tick();

    // Default configuration: 16 zero responses -> pass; one bit flipped -> fail
    b_gold = 8'h00;
    b_go();
    for (int i = 0; i < 16; i++) b_beat(8'h00);
    tick();
    chk("b_zero_pass", b_pass, 1);
    chk("b_zero_sig", b_sig, 0);
    b_go();
    for (int i = 0; i < 16; i++) b_beat((i == 7) ? 8'h04 : 8'h00);
    tick();
    chk("b_flip_fail", b_fail, 1);
    chk("b_flip_pass", b_pass, 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      a_start = ($urandom_range(0, 15) == 0);
      a_abort = ($urandom_range(0, 63) == 0);
      a_valid = ($urandom_range(0, 2) != 0);
      a_din   = 4'($urandom);
      a_gold  = (ma.ph == 2 && $urandom_range(0, 1) == 1) ? 4'(ma.sig) : 4'($urandom);
      b_start = ($urandom_range(0, 15) == 0);
      b_abort = ($urandom_range(0, 127) == 0);
      b_valid = ($urandom_range(0, 3) != 0);
      b_din   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      b_gold  = (mb.ph == 2 && $urandom_range(0, 1) == 1) ? 8'(mb.sig) : 8'($urandom);
      tick();
    end
    a_start = 0; a_abort = 0; a_valid = 0;
    b_start = 0; b_abort = 0; b_valid = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
